// File: rtl/ama_riscv_dmem_rsp.sv
`timescale 1ns/1ps
// ama_riscv_dmem_rsp
// Data-memory responder for the core's dmem request/response channel.
// Stores commit at the acceptance edge; loads are read at acceptance and
// returned in order through a small response queue after LATENCY cycles.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   req_valid/ready : request handshake (ready = queue not full)
//   req_addr        : byte address (upper bits beyond the memory wrap)
//   req_rtype       : 0 = load, 1 = store
//   req_dtype       : 0 = byte, 1 = half, 2 = word, 3 = illegal
//   req_wdata       : store data, right-justified
//   rsp_valid/ready : response handshake
//   rsp_data        : load data, right-justified, zero-extended
//   err_misaligned  : sticky, any accepted misaligned request
//   err_dtype       : sticky, any accepted request with dtype 3
//   load_cnt        : accepted loads (wraps)
//   store_cnt       : accepted stores (wraps)
module ama_riscv_dmem_rsp #(
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY   = 1,
  parameter int QDEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_rtype,
  input  logic [1:0]  req_dtype,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        err_misaligned,
  output logic        err_dtype,
  output logic [31:0] load_cnt,
  output logic [31:0] store_cnt
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  typedef enum logic [1:0] {
    DT_BYTE = 2'd0,
    DT_HALF = 2'd1,
    DT_WORD = 2'd2,
    DT_ILL  = 2'd3
  } dtype_e;

  logic [31:0]   mem [MEM_WORDS];

  logic [31:0]   q_data [QDEPTH];
  logic [2:0]    q_cnt  [QDEPTH];
  logic [QDEPTH-1:0] q_vld;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   last_data;

  dtype_e        dtype;
  logic          full;
  logic          accept;
  logic          misaligned;
  logic          illegal;
  logic          push;
  logic          pop;
  logic          do_write;
  logic [AW-1:0] idx;
  logic [4:0]    shamt;
  logic [31:0]   rd_shift;
  logic [31:0]   load_data;
  logic [31:0]   wdata_sh;
  logic [3:0]    be;
  logic          unused_addr;

  // Upper address bits are intentionally ignored so accesses wrap.
  assign unused_addr = ^req_addr[31:AW+2];

  assign dtype      = dtype_e'(req_dtype);
  assign full       = (count == CW'(QDEPTH));
  assign req_ready  = !full;
  assign accept     = req_valid && req_ready;
  assign misaligned = ((dtype == DT_HALF) && req_addr[0]) ||
                      ((dtype == DT_WORD) && (req_addr[1:0] != 2'b00));
  assign illegal    = (dtype == DT_ILL);
  assign push       = accept && !req_rtype;
  assign do_write   = accept && req_rtype && !misaligned && !illegal;

  assign idx      = req_addr[AW+1:2];
  assign shamt    = {req_addr[1:0], 3'b000};
  assign rd_shift = mem[idx] >> shamt;
  assign wdata_sh = req_wdata << shamt;

  always_comb begin
    load_data = '0;
    be        = '0;
    case (dtype)
      DT_BYTE: begin
        load_data = {24'd0, rd_shift[7:0]};
        be        = 4'b0001 << req_addr[1:0];
      end
      DT_HALF: begin
        load_data = {16'd0, rd_shift[15:0]};
        be        = 4'b0011 << req_addr[1:0];
      end
      DT_WORD: begin
        load_data = rd_shift;
        be        = 4'b1111;
      end
      default: begin
        load_data = '0;
        be        = '0;
      end
    endcase
    // Faulting loads still return a response, carrying zero.
    if (misaligned || illegal) load_data = '0;
  end

  assign rsp_valid = q_vld[rd_ptr] && (q_cnt[rd_ptr] == 3'd0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_data  = (count != '0) ? q_data[rd_ptr] : last_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: the memory array has no reset, so contents survive rst and it can
  // map onto RAM; only control state below is reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (do_write && be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      q_vld          <= '0;
      last_data      <= '0;
      err_misaligned <= 1'b0;
      err_dtype      <= 1'b0;
      load_cnt       <= '0;
      store_cnt      <= '0;
    end else begin
      // All populated entries age together; only the head can be popped.
      for (int i = 0; i < QDEPTH; i++) begin
        if (q_vld[i] && (q_cnt[i] != 3'd0)) q_cnt[i] <= q_cnt[i] - 3'd1;
      end

      if (push) begin
        q_data[wr_ptr] <= load_data;
        q_cnt[wr_ptr]  <= 3'(LATENCY - 1);
        q_vld[wr_ptr]  <= 1'b1;
        wr_ptr         <= ptr_inc(wr_ptr);
      end

      if (pop) begin
        q_vld[rd_ptr] <= 1'b0;
        rd_ptr        <= ptr_inc(rd_ptr);
      end

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Remember the head so rsp_data holds its value once the queue drains.
      if (count != '0) last_data <= q_data[rd_ptr];

      if (accept) begin
        if (req_rtype) store_cnt <= store_cnt + 32'd1;
        else           load_cnt  <= load_cnt + 32'd1;
        if (misaligned) err_misaligned <= 1'b1;
        if (illegal)    err_dtype      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ama_riscv_dmem_rsp.sv
`timescale 1ns/1ps
// Self-checking bench for ama_riscv_dmem_rsp. Three instances with different
// LATENCY/QDEPTH share the request bus; sel routes valid/ready to one of them
// and muxes its outputs onto the cur_* signals the checks look at.
module tb_ama_riscv_dmem_rsp;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;
  localparam logic [1:0] DB = 2'd0, DH = 2'd1, DW = 2'd2, DX = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_rtype;
  logic [1:0]  req_dtype;
  logic [31:0] req_wdata;
  logic        rsp_ready;

  logic [2:0]  req_ready_v, rsp_valid_v, errm_v, errd_v;
  logic [31:0] rsp_data_v  [3];
  logic [31:0] load_cnt_v  [3];
  logic [31:0] store_cnt_v [3];

  logic        cur_req_ready, cur_rsp_valid, cur_errm, cur_errd;
  logic [31:0] cur_rsp_data, cur_load_cnt, cur_store_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ama_riscv_dmem_rsp #(.MEM_WORDS(1024), .LATENCY(1), .QDEPTH(2)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && (sel == 2'd0)), .req_ready(req_ready_v[0]),
    .req_addr(req_addr), .req_rtype(req_rtype), .req_dtype(req_dtype),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_v[0]), .rsp_ready(rsp_ready && (sel == 2'd0)),
    .rsp_data(rsp_data_v[0]),
    .err_misaligned(errm_v[0]), .err_dtype(errd_v[0]),
    .load_cnt(load_cnt_v[0]), .store_cnt(store_cnt_v[0])
  );

  ama_riscv_dmem_rsp #(.MEM_WORDS(1024), .LATENCY(3), .QDEPTH(2)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && (sel == 2'd1)), .req_ready(req_ready_v[1]),
    .req_addr(req_addr), .req_rtype(req_rtype), .req_dtype(req_dtype),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_v[1]), .rsp_ready(rsp_ready && (sel == 2'd1)),
    .rsp_data(rsp_data_v[1]),
    .err_misaligned(errm_v[1]), .err_dtype(errd_v[1]),
    .load_cnt(load_cnt_v[1]), .store_cnt(store_cnt_v[1])
  );

  ama_riscv_dmem_rsp #(.MEM_WORDS(1024), .LATENCY(4), .QDEPTH(4)) dut_c (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && (sel == 2'd2)), .req_ready(req_ready_v[2]),
    .req_addr(req_addr), .req_rtype(req_rtype), .req_dtype(req_dtype),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_v[2]), .rsp_ready(rsp_ready && (sel == 2'd2)),
    .rsp_data(rsp_data_v[2]),
    .err_misaligned(errm_v[2]), .err_dtype(errd_v[2]),
    .load_cnt(load_cnt_v[2]), .store_cnt(store_cnt_v[2])
  );

  assign cur_req_ready = req_ready_v[sel];
  assign cur_rsp_valid = rsp_valid_v[sel];
  assign cur_errm      = errm_v[sel];
  assign cur_errd      = errd_v[sel];
  assign cur_rsp_data  = rsp_data_v[sel];
  assign cur_load_cnt  = load_cnt_v[sel];
  assign cur_store_cnt = store_cnt_v[sel];

  typedef struct {
    logic        rtype;
    logic [1:0]  dtype;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_errm;
    logic        exp_errd;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one request for a single cycle; returns at the negedge after the
  // acceptance edge with req_valid already dropped.
  task automatic do_req(input logic rt, input logic [1:0] dt, input logic [31:0] a,
                        input logic [31:0] d);
    req_rtype = rt; req_dtype = dt; req_addr = a; req_wdata = d; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Count acceptance-to-response edges, starting from 'start' edges already
  // elapsed; gives up after a bounded number of cycles.
  task automatic wait_rsp(input int start, output int n);
    n = start;
    while (!cur_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int nl, ns;

    //            rtype dtype addr        wdata         exp_data      errm  errd
    vecs[0]  = '{WR, DW, 32'h100,  32'h0000_0000, 32'h0,          1'b0, 1'b0};
    vecs[1]  = '{WR, DW, 32'h100,  32'hDEAD_BEEF, 32'h0,          1'b0, 1'b0};
    vecs[2]  = '{RD, DW, 32'h100,  32'h0,         32'hDEAD_BEEF,  1'b0, 1'b0};
    vecs[3]  = '{WR, DW, 32'h100,  32'h0000_0000, 32'h0,          1'b0, 1'b0};
    vecs[4]  = '{WR, DB, 32'h103,  32'h0000_00AA, 32'h0,          1'b0, 1'b0};
    vecs[5]  = '{WR, DH, 32'h100,  32'h0000_1234, 32'h0,          1'b0, 1'b0};
    vecs[6]  = '{RD, DW, 32'h100,  32'h0,         32'hAA00_1234,  1'b0, 1'b0};
    vecs[7]  = '{RD, DB, 32'h103,  32'h0,         32'h0000_00AA,  1'b0, 1'b0};
    vecs[8]  = '{RD, DH, 32'h102,  32'h0,         32'h0000_AA00,  1'b0, 1'b0};
    vecs[9]  = '{RD, DB, 32'h101,  32'h0,         32'h0000_0012,  1'b0, 1'b0};
    vecs[10] = '{RD, DH, 32'h101,  32'h0,         32'h0,          1'b1, 1'b0};
    vecs[11] = '{WR, DW, 32'h102,  32'h0000_0020, 32'h0,          1'b1, 1'b0};
    vecs[12] = '{RD, DW, 32'h100,  32'h0,         32'hAA00_1234,  1'b1, 1'b0};
    vecs[13] = '{RD, DX, 32'h100,  32'h0,         32'h0,          1'b1, 1'b1};
    vecs[14] = '{WR, DW, 32'h1100, 32'hCAFE_F00D, 32'h0,          1'b1, 1'b1};
    vecs[15] = '{WR, DB, 32'h101,  32'hFFFF_FF55, 32'h0,          1'b1, 1'b1};
    vecs[16] = '{RD, DW, 32'h100,  32'h0,         32'hCAFE_550D,  1'b1, 1'b1};

    sel = 2'd0; rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_addr = '0; req_rtype = 1'b0; req_dtype = 2'd0; req_wdata = '0;
    repeat (2) @(negedge clk);

    check("rst_req_ready", {31'd0, cur_req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, cur_rsp_valid}, 32'd0);
    check("rst_rsp_data", cur_rsp_data, 32'd0);
    check("rst_err_flags", {30'd0, cur_errm, cur_errd}, 32'd0);
    check("rst_load_cnt", cur_load_cnt, 32'd0);
    check("rst_store_cnt", cur_store_cnt, 32'd0);
    rst = 1'b0;

    // Table-driven pass on the LATENCY=1 instance, one request per cycle.
    rsp_ready = 1'b1;
    nl = 0; ns = 0;
    for (int i = 0; i < 17; i++) begin
      do_req(vecs[i].rtype, vecs[i].dtype, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].rtype) ns++; else nl++;
      check($sformatf("vec%0d_rsp_valid", i), {31'd0, cur_rsp_valid}, {31'd0, !vecs[i].rtype});
      if (!vecs[i].rtype) check($sformatf("vec%0d_rsp_data", i), cur_rsp_data, vecs[i].exp_data);
      check($sformatf("vec%0d_err", i), {30'd0, cur_errm, cur_errd},
            {30'd0, vecs[i].exp_errm, vecs[i].exp_errd});
    end
    @(negedge clk);
    check("a_load_cnt", cur_load_cnt, 32'(nl));
    check("a_store_cnt", cur_store_cnt, 32'(ns));
    check("a_drained_valid", {31'd0, cur_rsp_valid}, 32'd0);
    check("a_drained_data_hold", cur_rsp_data, 32'hCAFE_550D);

    // Backpressure on LATENCY=3, QDEPTH=2.
    sel = 2'd1; rsp_ready = 1'b0;
    do_req(WR, DW, 32'h300, 32'h0000_00A1);
    do_req(WR, DW, 32'h304, 32'h0000_00B2);
    do_req(WR, DW, 32'h308, 32'h0000_00C3);
    do_req(RD, DW, 32'h300, 32'h0);
    do_req(RD, DW, 32'h304, 32'h0);
    check("bp_full_ready", {31'd0, cur_req_ready}, 32'd0);
    check("bp_full_cnt", cur_load_cnt, 32'd2);
    req_rtype = RD; req_dtype = DW; req_addr = 32'h308; req_valid = 1'b1;
    @(negedge clk);
    check("bp_head_valid", {31'd0, cur_rsp_valid}, 32'd1);
    check("bp_head_data", cur_rsp_data, 32'h0000_00A1);
    check("bp_stall_ready", {31'd0, cur_req_ready}, 32'd0);
    @(negedge clk);
    check("bp_stable_data", cur_rsp_data, 32'h0000_00A1);
    check("bp_stable_valid", {31'd0, cur_rsp_valid}, 32'd1);
    check("bp_stall_cnt", cur_load_cnt, 32'd2);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_pop1_data", cur_rsp_data, 32'h0000_00B2);
    check("bp_pop1_ready", {31'd0, cur_req_ready}, 32'd1);
    check("bp_pop1_cnt", cur_load_cnt, 32'd2);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_third_accepted", cur_load_cnt, 32'd3);
    check("bp_third_not_ready", {31'd0, cur_rsp_valid}, 32'd0);
    check("bp_third_head_data", cur_rsp_data, 32'h0000_00C3);
    wait_rsp(1, n);
    check("bp_third_latency", 32'(n), 32'd3);
    check("bp_third_data", cur_rsp_data, 32'h0000_00C3);
    @(negedge clk);
    check("bp_empty_valid", {31'd0, cur_rsp_valid}, 32'd0);
    check("bp_empty_hold", cur_rsp_data, 32'h0000_00C3);
    rsp_ready = 1'b0;

    // Write-after-read and read-after-write on LATENCY=4.
    sel = 2'd2; rsp_ready = 1'b1;
    do_req(WR, DW, 32'h200, 32'h1111_1111);
    req_rtype = RD; req_dtype = DW; req_addr = 32'h200; req_valid = 1'b1;
    @(negedge clk);
    req_rtype = WR; req_wdata = 32'h2222_2222;
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(2, n);
    check("war_latency", 32'(n), 32'd4);
    check("war_data", cur_rsp_data, 32'h1111_1111);
    @(negedge clk);
    do_req(RD, DW, 32'h200, 32'h0);
    wait_rsp(1, n);
    check("raw_latency", 32'(n), 32'd4);
    check("raw_data", cur_rsp_data, 32'h2222_2222);
    @(negedge clk);

    // Reset with two loads queued.
    rsp_ready = 1'b0;
    do_req(RD, DW, 32'h200, 32'h0);
    do_req(RD, DW, 32'h200, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", {31'd0, cur_rsp_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, cur_req_ready}, 32'd1);
    check("mid_rst_load_cnt", cur_load_cnt, 32'd0);
    check("mid_rst_store_cnt", cur_store_cnt, 32'd0);
    check("mid_rst_data", cur_rsp_data, 32'd0);
    check("mid_rst_errm_a", {31'd0, errm_v[0]}, 32'd0);
    repeat (6) @(negedge clk);
    check("mid_rst_dropped", {31'd0, cur_rsp_valid}, 32'd0);
    rsp_ready = 1'b1;
    do_req(RD, DW, 32'h200, 32'h0);
    wait_rsp(1, n);
    check("post_rst_latency", 32'(n), 32'd4);
    check("post_rst_data", cur_rsp_data, 32'h2222_2222);
    check("post_rst_load_cnt", cur_load_cnt, 32'd1);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
